// File: rtl/word_serializer_if.sv
// Load handshake bundle for word_serializer: the source presents a word on d
// with ld, and the serializer answers with ld_ready.
interface word_serializer_if #(
  parameter int unsigned W = 4
);
  logic         ld;
  logic [W-1:0] d;
  logic         ld_ready;

  modport master (output ld, output d, input ld_ready);
  modport slave  (input ld, input d, output ld_ready);
endinterface

// File: rtl/word_serializer.sv
// word_serializer: parallel-in, serial-out framing transmitter.
// Frame = start bit (0), W data bits LSB first, optional even parity, stop bit (1).
// The serial line idles high. Define WORD_SER_PARITY_EN to compile in the parity bit.
module word_serializer #(
  parameter int unsigned W = 4
) (
  input  logic               clk,
  input  logic               rst,
  word_serializer_if.slave   lif,
  output logic               sout,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

`ifdef WORD_SER_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_shift, w_shift_nxt, w_shifted;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_sout, r_busy, r_done;
  logic             w_sout_nxt, w_busy_nxt, w_done_nxt;
  logic             w_ready, w_accept;
`ifdef WORD_SER_PARITY_EN
  logic             r_par, w_par_nxt;
`endif

  assign w_ready      = (r_state == IDLE) || (r_state == STOP);
  assign w_accept     = lif.ld && w_ready;
  assign lif.ld_ready = w_ready;
  assign w_shifted    = W'({1'b1, r_shift} >> 1);

  assign sout = r_sout;
  assign busy = r_busy;
  assign done = r_done;

  // Next-state, datapath and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
`ifdef WORD_SER_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      IDLE, STOP: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_shift_nxt = lif.d;
          w_cnt_nxt   = '0;
`ifdef WORD_SER_PARITY_EN
          w_par_nxt   = ^lif.d;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        w_state_nxt = DATA;
        w_shift_nxt = w_shifted;
      end
      DATA: begin
        w_shift_nxt = w_shifted;
        if (r_cnt == LAST) begin
`ifdef WORD_SER_PARITY_EN
          w_state_nxt = PAR;
`else
          w_state_nxt = STOP;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`ifdef WORD_SER_PARITY_EN
      PAR: w_state_nxt = STOP;
`endif
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state. The
    // shift register is advanced on the same edge that registers its bit 0,
    // hence it runs one bit ahead of sout while in DATA.
    w_sout_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_sout_nxt = 1'b0;
      DATA:    w_sout_nxt = r_shift[0];
`ifdef WORD_SER_PARITY_EN
      PAR:     w_sout_nxt = r_par;
`endif
      default: w_sout_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == STOP);
  end

  // State, datapath and output registers; reset overrides any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '1;
      r_cnt   <= '0;
      r_sout  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef WORD_SER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sout  <= w_sout_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
`ifdef WORD_SER_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Directed testbench for word_serializer (W=4) with an expected-bit scoreboard.
// Builds with or without WORD_SER_PARITY_EN.
module tb_word_serializer;

  localparam int unsigned W = 4;
`ifdef WORD_SER_PARITY_EN
  localparam int unsigned FL = W + 3;
`else
  localparam int unsigned FL = W + 2;
`endif

  typedef struct packed {
    logic sout;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sout, busy, done;

  word_serializer_if #(.W(W)) lif ();

  word_serializer #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .lif  (lif),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] hist = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line activity for one accepted word, from the frame definition.
  task automatic push_frame(input logic [W-1:0] w);
    exp_q.push_back('{sout: 1'b0, done: 1'b0});
    for (int i = 0; i < int'(W); i++) exp_q.push_back('{sout: w[i], done: 1'b0});
`ifdef WORD_SER_PARITY_EN
    exp_q.push_back('{sout: ^w, done: 1'b0});
`endif
    exp_q.push_back('{sout: 1'b1, done: 1'b1});
  endtask

  // Advance one clock and check outputs against the scoreboard (idle if empty).
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    hist = {hist[30:0], sout};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sout", 32'(sout), 32'(e.sout));
      chk("done", 32'(done), 32'(e.done));
      chk("busy", 32'(busy), 32'd1);
      chk("ld_ready", 32'(lif.ld_ready), 32'(e.done));
    end else begin
      chk("idle_sout", 32'(sout), 32'd1);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_ld_ready", 32'(lif.ld_ready), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lif.ld = 1'b0;
    lif.d  = '0;

    // Reset for two cycles, then idle with ld low.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (3) step();

    // Reset has priority over a simultaneous accept.
    rst = 1'b1; lif.ld = 1'b1; lif.d = 4'hF;
    step();
    rst = 1'b0; lif.ld = 1'b0;
    step();

    // Single frame 4'b1011.
    lif.ld = 1'b1; lif.d = 4'b1011;
    push_frame(4'b1011);
    step();
    lif.ld = 1'b0; lif.d = 4'h0;
    repeat (FL - 1) step();
`ifdef WORD_SER_PARITY_EN
    chk("seq_single", hist & 32'h7F, 32'b0110111);
`else
    chk("seq_single", hist & 32'h3F, 32'b011011);
`endif
    repeat (2) step();

    // Back-to-back: ld held high, word changed during the first STOP cycle.
    lif.ld = 1'b1; lif.d = 4'hA;
    push_frame(4'hA);
    repeat (FL) step();
    lif.d = 4'h5;
    push_frame(4'h5);
    step();
    lif.ld = 1'b0;
    repeat (FL - 1) step();
`ifdef WORD_SER_PARITY_EN
    chk("seq_b2b", hist & 32'h3FFF, 32'b00101010101001);
`else
    chk("seq_b2b", hist & 32'hFFF, 32'b001011010101);
`endif
    repeat (2) step();

    // Load pulse mid-DATA is ignored.
    lif.ld = 1'b1; lif.d = 4'h0;
    push_frame(4'h0);
    step();
    lif.ld = 1'b0;
    repeat (2) step();
    lif.ld = 1'b1; lif.d = 4'hF;
    step();
    lif.ld = 1'b0;
    repeat (FL - 4) step();
`ifdef WORD_SER_PARITY_EN
    chk("seq_busy_ld", hist & 32'h7F, 32'b0000001);
`else
    chk("seq_busy_ld", hist & 32'h3F, 32'b000001);
`endif
    repeat (3) step();

    // Reset during the second data bit aborts the frame.
    lif.ld = 1'b1; lif.d = 4'h0;
    push_frame(4'h0);
    step();
    lif.ld = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    repeat (3) step();

    // New word after the abort.
    lif.ld = 1'b1; lif.d = 4'h3;
    push_frame(4'h3);
    step();
    lif.ld = 1'b0;
    repeat (FL - 1) step();
`ifdef WORD_SER_PARITY_EN
    chk("seq_after_rst", hist & 32'h7F, 32'b0110001);
`else
    chk("seq_after_rst", hist & 32'h3F, 32'b011001);
`endif
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-in, serial-out framing transmitter: accepts a W-bit word through a valid/ready load handshake and shifts it out one bit per clock, LSB first, wrapped in a start bit and a stop bit (optional parity). It is the unloading end of the bank of parallel-load data registers: the register bank captures a word, and this block drains it onto a single serial line for the downstream serial receiver. Serial line idles high, matching the all-ones idle/reset value of the register bank.

## Interface
Parameters:
- `W`, 4, data word width; legal range 1..32.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high (sampled on rising `clk`).
- `ld`  in  1  load request; word on `d` is valid.
- `d`  in  W  parallel data word; sampled only on an accepted load.
- `ld_ready`  out  1  block can accept a word this cycle.
- `sout`  out  1  serial data line; idle = 1.
- `busy`  out  1  a frame is in progress (any state except IDLE).
- `done`  out  1  one-cycle pulse during the stop bit of each frame.

## Operation
- States: IDLE, START, DATA, PAR (only with parity), STOP.
- Accept condition: `ld && ld_ready` at a rising edge; `d` is copied into an internal W-bit shift register and the bit counter is cleared.
- `ld_ready` = 1 in IDLE and STOP, 0 otherwise. `ld` outside those states is ignored; no word is queued.
- IDLE: `sout`=1. On accept -> START.
- START: `sout`=0 for 1 cycle -> DATA.
- DATA: `sout` = shift register bit 0; shift right by one each cycle; counter increments; after W cycles (counter == W-1) -> PAR if parity is enabled, else -> STOP.
- PAR: `sout` = parity bit for 1 cycle -> STOP.
- STOP: `sout`=1, `done`=1 for 1 cycle. On accept -> START (back-to-back, no idle gap); else -> IDLE.
- Counter width is clog2(W), min 1 bit; W=1 gives exactly one DATA cycle.
- Output flops are registered: `sout`, `busy`, `done` come from flops, not from combinational decode of `ld`.

## Timing
- Reset values: state IDLE, `sout`=1, `ld_ready`=1, `busy`=0, `done`=0, shift register all-ones, counter 0.
- Reset has priority over all other inputs, including an accept in the same cycle. Reset mid-frame aborts the frame; `sout` is 1 on the cycle after the reset edge and the word is lost.
- Accept at edge E0: START occupies cycle E0..E1; data bit i is on `sout` in cycle E(1+i); PAR in cycle E(W+1); STOP in cycle E(W+1) without parity, E(W+2) with parity.
- Frame length: W+2 cycles without parity, W+3 with parity. Sustained throughput with `ld` held high is one word per frame length.
- `done` is high in exactly the STOP cycle; an accept in that same cycle is legal.
- `d` may change freely after the accept edge.

## Configuration
- Macro `WORD_SER_PARITY_EN`:
  - Defined: PAR state is compiled in. Parity bit = even parity = XOR of the W data bits, computed at accept time.
  - Not defined: PAR state and parity logic are absent, and DATA goes straight to STOP.
- Port list is identical in both builds.

## Test plan
- Reset then idle, W=4: assert `rst` for 2 cycles -> `sout`=1, `ld_ready`=1, `busy`=0, `done`=0. These values hold with `ld`=0.
- Single frame, W=4, no parity: load `d`=4'b1011 -> `sout` = 0,1,1,0,1,1 on consecutive cycles. `done`=1 only on the sixth cycle. The block then returns to IDLE.
- Parity build: load `d`=4'b1011 -> `sout` = 0,1,1,0,1,1,1, where parity=1. Load 4'b0011 -> `sout` = 0,1,1,0,0,0,1, where parity=0.
- Back-to-back, no parity: hold `ld`=1 with `d`=4'hA, then `d`=4'h5 in the STOP cycle -> `sout` = 0,0,1,0,1,1,0,1,0,1,0,1 with no idle cycle between frames.
- Load while busy: pulse `ld` with `d`=4'hF mid-DATA of a 4'h0 frame -> the pulse is ignored and the frame completes as 0,0,0,0,0,1. The block then returns to IDLE.
- Reset mid-frame: assert `rst` during the second DATA bit -> next cycle `sout`=1, state IDLE, `done` never pulses. A new load of 4'h3 afterwards produces 0,1,1,0,0,1.
